// File: rtl/branch_resolver.sv
// branch_resolver: checks each resolved branch against its prediction,
// flushes the pipeline and redirects fetch on a mispredict, emits a
// predictor-update pulse per branch and keeps saturating perf counters.
module branch_resolver #(
  parameter int NUM_WARPS    = 4,
  parameter int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int PC_BITS      = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_BITS    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [NW_BITS-1:0]   res_wid,
  input  logic [PC_BITS-1:0]   res_pc,
  input  logic                 res_taken,
  input  logic [PC_BITS-1:0]   res_target,
  input  logic                 pred_taken,
  input  logic [PC_BITS-1:0]   pred_target,
  output logic                 branch_mispredict_flush,
  output logic                 redir_valid,
  input  logic                 redir_ready,
  output logic [NW_BITS-1:0]   redir_wid,
  output logic [PC_BITS-1:0]   redir_pc,
  output logic                 upd_valid,
  output logic [NW_BITS-1:0]   upd_wid,
  output logic [PC_BITS-1:0]   upd_pc,
  output logic                 upd_taken,
  output logic [PC_BITS-1:0]   upd_target,
  output logic [PERF_BITS-1:0] perf_branches,
  output logic [PERF_BITS-1:0] perf_mispredicts
);

  localparam int CNT_BITS = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(FLUSH_CYCLES - 1);
  localparam logic [PERF_BITS-1:0] PERF_MAX = {PERF_BITS{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, REDIRECT = 2'd2} state_t;

  state_t               state_reg, state_next;
  logic [CNT_BITS-1:0]  cnt_reg;
  logic [NW_BITS-1:0]   redir_wid_reg;
  logic [PC_BITS-1:0]   redir_pc_reg;
  logic                 upd_valid_reg;
  logic [NW_BITS-1:0]   upd_wid_reg;
  logic [PC_BITS-1:0]   upd_pc_reg;
  logic                 upd_taken_reg;
  logic [PC_BITS-1:0]   upd_target_reg;
  logic [PERF_BITS-1:0] perf_branches_reg;
  logic [PERF_BITS-1:0] perf_mispredicts_reg;

  logic               accept;
  logic [PC_BITS-1:0] fallthrough;
  logic [PC_BITS-1:0] actual_npc;
  logic [PC_BITS-1:0] pred_npc;
  logic               mispredict;

  // Only compare next-PCs, so a taken prediction to the fallthrough address
  // is equivalent to not-taken; the +4 wraps modulo 2^PC_BITS.
  assign res_ready   = (state_reg == IDLE);
  assign accept      = res_valid && res_ready;
  assign fallthrough = res_pc + PC_BITS'(4);
  assign actual_npc  = res_taken ? res_target : fallthrough;
  assign pred_npc    = pred_taken ? pred_target : fallthrough;
  assign mispredict  = (actual_npc != pred_npc);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (accept && mispredict) state_next = FLUSH;
      FLUSH:    if (cnt_reg == '0) state_next = REDIRECT;
      REDIRECT: if (redir_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Flush down-counter: loaded on the mispredicting accept, runs during FLUSH
  always_ff @(posedge clk) begin
    if (reset)                             cnt_reg <= '0;
    else if (accept && mispredict)         cnt_reg <= CNT_LOAD;
    else if (state_reg == FLUSH && cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
  end

  // Capture redirect target and predictor-update payload on every accept
  always_ff @(posedge clk) begin
    if (reset) begin
      redir_wid_reg  <= '0;
      redir_pc_reg   <= '0;
      upd_valid_reg  <= 1'b0;
      upd_wid_reg    <= '0;
      upd_pc_reg     <= '0;
      upd_taken_reg  <= 1'b0;
      upd_target_reg <= '0;
    end else begin
      upd_valid_reg <= accept;
      if (accept) begin
        redir_wid_reg  <= res_wid;
        redir_pc_reg   <= actual_npc;
        upd_wid_reg    <= res_wid;
        upd_pc_reg     <= res_pc;
        upd_taken_reg  <= res_taken;
        upd_target_reg <= res_target;
      end
    end
  end

  // Saturating branch and mispredict counters
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_branches_reg    <= '0;
      perf_mispredicts_reg <= '0;
    end else if (accept) begin
      if (perf_branches_reg != PERF_MAX)
        perf_branches_reg <= perf_branches_reg + 1'b1;
      if (mispredict && perf_mispredicts_reg != PERF_MAX)
        perf_mispredicts_reg <= perf_mispredicts_reg + 1'b1;
    end
  end

  // Output decode: flush and redirect come straight from state, so they can
  // never overlap; redirect payload is zeroed when no request is pending.
  always_comb begin
    branch_mispredict_flush = (state_reg == FLUSH);
    redir_valid             = (state_reg == REDIRECT);
    redir_wid               = redir_valid ? redir_wid_reg : '0;
    redir_pc                = redir_valid ? redir_pc_reg : '0;
    upd_valid               = upd_valid_reg;
    upd_wid                 = upd_wid_reg;
    upd_pc                  = upd_pc_reg;
    upd_taken               = upd_taken_reg;
    upd_target              = upd_target_reg;
    perf_branches           = perf_branches_reg;
    perf_mispredicts        = perf_mispredicts_reg;
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed testbench for branch_resolver (PERF_BITS=4 to reach saturation).
module tb_branch_resolver;

  localparam int NW = 2;
  localparam int PB = 32;
  localparam int PF = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          res_valid;
  logic          res_ready;
  logic [NW-1:0] res_wid;
  logic [PB-1:0] res_pc;
  logic          res_taken;
  logic [PB-1:0] res_target;
  logic          pred_taken;
  logic [PB-1:0] pred_target;
  logic          branch_mispredict_flush;
  logic          redir_valid;
  logic          redir_ready;
  logic [NW-1:0] redir_wid;
  logic [PB-1:0] redir_pc;
  logic          upd_valid;
  logic [NW-1:0] upd_wid;
  logic [PB-1:0] upd_pc;
  logic          upd_taken;
  logic [PB-1:0] upd_target;
  logic [PF-1:0] perf_branches;
  logic [PF-1:0] perf_mispredicts;

  int n_tests = 0;
  int n_fail  = 0;

  branch_resolver #(
    .NUM_WARPS(4), .NW_BITS(NW), .PC_BITS(PB), .FLUSH_CYCLES(2), .PERF_BITS(PF)
  ) dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_ready(res_ready), .res_wid(res_wid),
    .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .branch_mispredict_flush(branch_mispredict_flush),
    .redir_valid(redir_valid), .redir_ready(redir_ready),
    .redir_wid(redir_wid), .redir_pc(redir_pc),
    .upd_valid(upd_valid), .upd_wid(upd_wid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  // One comparison: count it, report a mismatch
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a result for one edge (accepted only if res_ready)
  task automatic drive(input logic [NW-1:0] wid, input logic [PB-1:0] pc,
                       input logic tk, input logic [PB-1:0] tgt,
                       input logic ptk, input logic [PB-1:0] ptgt);
    res_valid   = 1'b1;
    res_wid     = wid;
    res_pc      = pc;
    res_taken   = tk;
    res_target  = tgt;
    pred_taken  = ptk;
    pred_target = ptgt;
  endtask

  // Bounded wait for a redirect request
  task automatic wait_redir(input string tag);
    for (int i = 0; i < 20 && !redir_valid; i++) tick();
    check(tag, redir_valid, 1);
  endtask

  // Accept the pending redirect in one cycle
  task automatic complete_redir();
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; res_valid = 1'b0; redir_ready = 1'b0;
    res_wid = '0; res_pc = '0; res_taken = 1'b0; res_target = '0;
    pred_taken = 1'b0; pred_target = '0;
    tick(); tick();

    // Reset state
    check("rst_res_ready", res_ready, 1);
    check("rst_upd_valid", upd_valid, 0);
    check("rst_flush", branch_mispredict_flush, 0);
    check("rst_redir_valid", redir_valid, 0);
    check("rst_perf_br", perf_branches, 0);
    check("rst_perf_mis", perf_mispredicts, 0);
    reset = 1'b0;
    tick();

    // Correct not-taken
    drive(2'd1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    res_valid = 1'b0;
    $display("[TB] txn correct-not-taken pc=0x100");
    check("nt_upd_valid", upd_valid, 1);
    check("nt_upd_taken", upd_taken, 0);
    check("nt_upd_pc", upd_pc, 32'h100);
    check("nt_upd_wid", upd_wid, 1);
    check("nt_flush", branch_mispredict_flush, 0);
    check("nt_res_ready", res_ready, 1);
    check("nt_perf_br", perf_branches, 1);
    check("nt_perf_mis", perf_mispredicts, 0);
    tick();
    check("nt_upd_pulse_end", upd_valid, 0);

    // Direction mispredict
    drive(2'd2, 32'h200, 1'b1, 32'h400, 1'b0, 32'h0);
    tick();
    res_valid = 1'b0;
    $display("[TB] txn dir-mispredict pc=0x200 -> 0x400");
    check("dm_flush_t1", branch_mispredict_flush, 1);
    check("dm_redir_t1", redir_valid, 0);
    check("dm_res_ready_t1", res_ready, 0);
    check("dm_upd_target", upd_target, 32'h400);
    check("dm_perf_mis", perf_mispredicts, 1);
    tick();
    check("dm_flush_t2", branch_mispredict_flush, 1);
    check("dm_redir_t2", redir_valid, 0);
    tick();
    check("dm_flush_t3", branch_mispredict_flush, 0);
    check("dm_redir_t3", redir_valid, 1);
    check("dm_redir_pc", redir_pc, 32'h400);
    check("dm_redir_wid", redir_wid, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("dm_stall_valid", redir_valid, 1);
      check("dm_stall_pc", redir_pc, 32'h400);
      check("dm_stall_flush", branch_mispredict_flush, 0);
    end
    check("dm_ready_before", res_ready, 0);
    complete_redir();
    check("dm_redir_done", redir_valid, 0);
    check("dm_ready_after", res_ready, 1);

    // Target mispredict
    drive(2'd3, 32'h300, 1'b1, 32'h80, 1'b1, 32'h90);
    tick();
    res_valid = 1'b0;
    $display("[TB] txn target-mispredict pc=0x300 -> 0x80");
    check("tm_perf_mis", perf_mispredicts, 2);
    wait_redir("tm_wait_redir");
    check("tm_redir_pc", redir_pc, 32'h80);
    complete_redir();

    // Equivalence with wrapping fallthrough
    drive(2'd0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
    tick();
    res_valid = 1'b0;
    $display("[TB] txn wrap-equivalence pc=0xfffffffc");
    check("wr_upd_valid", upd_valid, 1);
    check("wr_flush", branch_mispredict_flush, 0);
    check("wr_res_ready", res_ready, 1);
    check("wr_perf_br", perf_branches, 4);
    check("wr_perf_mis", perf_mispredicts, 2);

    // Four correct branches back to back
    for (int i = 0; i < 4; i++) begin
      drive(2'(i), 32'h1000 + 32'(i) * 32'h10, 1'b1, 32'h2000, 1'b1, 32'h2000);
      tick();
      $display("[TB] txn b2b %0d", i);
      check("b2b_upd_valid", upd_valid, 1);
      check("b2b_upd_pc", upd_pc, 32'h1000 + 64'(i) * 64'h10);
    end
    res_valid = 1'b0;
    check("b2b_perf_br", perf_branches, 8);

    // Mispredict followed by a waiting result
    drive(2'd1, 32'h500, 1'b1, 32'h600, 1'b0, 32'h0);
    tick();
    drive(2'd2, 32'h700, 1'b0, 32'h0, 1'b0, 32'h0);
    $display("[TB] txn mispredict-then-held pc=0x500/0x700");
    check("hold_ready_t1", res_ready, 0);
    tick();
    check("hold_no_upd", upd_valid, 0);
    check("hold_ready_t2", res_ready, 0);
    wait_redir("hold_wait_redir");
    check("hold_redir_pc", redir_pc, 32'h600);
    check("hold_perf_br", perf_branches, 9);
    complete_redir();
    check("hold_ready_idle", res_ready, 1);
    tick();
    res_valid = 1'b0;
    check("hold_upd_valid", upd_valid, 1);
    check("hold_upd_pc", upd_pc, 32'h700);
    check("hold_perf_br2", perf_branches, 10);
    check("hold_perf_mis", perf_mispredicts, 3);

    // Reset while in REDIRECT
    drive(2'd0, 32'h800, 1'b1, 32'h900, 1'b0, 32'h0);
    tick();
    res_valid = 1'b0;
    wait_redir("rr_wait_redir");
    reset = 1'b1;
    tick();
    $display("[TB] txn reset-in-redirect");
    check("rr_redir_valid", redir_valid, 0);
    check("rr_flush", branch_mispredict_flush, 0);
    check("rr_res_ready", res_ready, 1);
    check("rr_perf_br", perf_branches, 0);
    check("rr_perf_mis", perf_mispredicts, 0);
    reset = 1'b0;
    tick();

    // Saturation of the 4-bit counters
    for (int i = 0; i < 16; i++) begin
      drive(2'd0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
      tick();
      res_valid = 1'b0;
      wait_redir("sat_wait_redir");
      check("sat_redir_pc", redir_pc, 32'h44);
      complete_redir();
      if (i == 14) check("sat_mis_15", perf_mispredicts, 15);
    end
    $display("[TB] txn saturation 16 mispredicts");
    check("sat_perf_mis", perf_mispredicts, 15);
    check("sat_perf_br", perf_branches, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Sits directly downstream of the execution staller and branch ALU. Consumes each resolved branch/jump and compares the actual next PC with the predicted next PC.
- On a mispredict it drives the `branch_mispredict_flush` pulse back to the staller and issue logic, then holds a redirect request to fetch until fetch accepts it.
- Emits a one-cycle predictor-update pulse per resolved branch and keeps saturating perf counters.

Parameters:
- NUM_WARPS, 4, number of warps; sets warp-id width.
- NW_BITS, `CLOG2(NUM_WARPS)`, warp-id width (min 1).
- PC_BITS, 32, PC and target width.
- FLUSH_CYCLES, 2, cycles the flush stays asserted (must be >= 1).
- PERF_BITS, 32, perf counter width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- res_valid  input  1  resolved branch available
- res_ready  output  1  resolver can accept a result
- res_wid  input  NW_BITS  warp of branch
- res_pc  input  PC_BITS  branch PC
- res_taken  input  1  actual direction
- res_target  input  PC_BITS  actual target
- pred_taken  input  1  predicted direction
- pred_target  input  PC_BITS  predicted target
- branch_mispredict_flush  output  1  flush to staller/issue
- redir_valid  output  1  redirect request to fetch
- redir_ready  input  1  fetch accepts redirect
- redir_wid  output  NW_BITS  warp to redirect
- redir_pc  output  PC_BITS  corrected PC
- upd_valid  output  1  predictor update pulse
- upd_wid  output  NW_BITS  update warp
- upd_pc  output  PC_BITS  update PC
- upd_taken  output  1  update direction
- upd_target  output  PC_BITS  update target
- perf_branches  output  PERF_BITS  resolved branch count
- perf_mispredicts  output  PERF_BITS  mispredict count

Behaviour:
- Reset values:
  - All outputs except res_ready are 0 and all internal registers clear; state = IDLE.
  - res_ready is 1 in IDLE, so it reads 1 while reset is held.
- Reset mid-operation (any state) aborts: the pending redirect is dropped, flush deasserts, state returns to IDLE on the next edge.
- Handshake:
  - A result is accepted when res_valid && res_ready.
  - res_ready = (state == IDLE), purely from state, with no combinational path from res_valid.
  - Redirect completes when redir_valid && redir_ready.
  - redir_wid and redir_pc stay stable while redir_valid is high.
- Arithmetic:
  - fallthrough = res_pc + 4, modulo 2^PC_BITS (wraps silently).
  - actual_npc = res_taken ? res_target : fallthrough.
  - pred_npc = pred_taken ? pred_target : fallthrough.
  - mispredict = (actual_npc != pred_npc). Taken-vs-not-taken with pred_target == fallthrough is NOT a mispredict.
- Acceptance at cycle T, registered into the resolver:
  - T+1: upd_valid = 1 for exactly one cycle, carrying wid, pc, res_taken, res_target. This happens for every accepted branch.
  - T+1: perf_branches increments.
  - On mispredict, also at T+1: perf_mispredicts increments.
  - Both perf counters saturate at all-ones.
- FSM states: IDLE, FLUSH, REDIRECT.
  - IDLE: accept with mispredict -> FLUSH. Accept without mispredict -> stay in IDLE (back-to-back accepts allowed every cycle).
  - FLUSH:
    - branch_mispredict_flush = 1.
    - A down-counter loaded with FLUSH_CYCLES-1 on entry; at 0 -> REDIRECT.
    - Flush is high for exactly FLUSH_CYCLES consecutive cycles, T+1 .. T+FLUSH_CYCLES.
  - REDIRECT:
    - redir_valid = 1 with redir_pc = actual_npc, redir_wid = captured wid.
    - On redir_ready -> IDLE; res_ready rises the following cycle (no same-cycle bypass).
    - Holds indefinitely if fetch stalls.
- Flush and redirect never overlap.
- No result is accepted from the cycle after a mispredict accept until back in IDLE.

Test Plan:
- Correct not-taken: res_pc=0x100, taken=0, pred_taken=0 -> upd_valid 1 cycle at T+1 with taken=0; no flush; res_ready stays 1; perf_branches=1, perf_mispredicts=0.
- Direction mispredict: res_pc=0x200, taken=1, target=0x400, pred_taken=0, FLUSH_CYCLES=2 ->
  - flush high at T+1 and T+2 only;
  - redir_valid from T+3 with redir_pc=0x400;
  - redir_ready held low 5 cycles -> redir_valid and redir_pc stay stable;
  - after ready, res_ready=1 one cycle later.
- Target mispredict: taken=1, target=0x80, pred_taken=1, pred_target=0x90 -> redir_pc=0x80, perf_mispredicts increments.
- Equivalence and wrap: res_pc=0xFFFFFFFC, taken=0, pred_taken=1, pred_target=0x0 -> no mispredict (fallthrough wraps to 0x0).
- Back-to-back: 4 correct branches on consecutive cycles -> 4 upd_valid pulses, perf_branches=4. A mispredict followed immediately by another valid result -> second result held (res_ready=0) until the redirect completes.
- Reset mid-operation and saturation:
  - reset asserted in REDIRECT -> redir_valid=0 next cycle, state IDLE, counters 0;
  - perf_mispredicts preloaded via PERF_BITS=4 at 15 plus one more mispredict -> stays 15.
